// File: rtl/izh_pkg.sv
// Shared types and helpers for the Izhikevich neuron array.
//   state_t    : FSM state encoding, also exported on debug_state
//   DEF_*      : per-neuron parameter values restored on reset
//   frame_len  : serial load frame length in bits
//   sat        : clamp a wide signed value to a w-bit signed range
package izh_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FETCH = 3'd2,
      S_CALC  = 3'd3,
      S_WB    = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int DEF_A = 5;
   localparam int DEF_B = 51;
   localparam int DEF_C = -65;
   localparam int DEF_D = 8;
   localparam int DEF_V_RST = -65;

   function automatic int frame_len(input int idx_w, input int p_w);
      return idx_w + 4 * p_w;
   endfunction

   // Result is returned 64 bits wide; callers truncate to w bits.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

endpackage

// File: rtl/izh_update_dp.sv
// Combinational Euler update for one neuron.
//   in : v, u (V_W signed), a/b/c/d (P_W signed), stim (STIM_W signed)
//   out: v_out/u_out = state to write back (already spike-reset),
//        spike = v_new reached VPEAK
module izh_update_dp
   import izh_pkg::*;
#(
   parameter int V_W    = 16,
   parameter int P_W    = 8,
   parameter int STIM_W = 8,
   parameter int K_SQ   = 10,
   parameter int VPEAK  = 30
) (
   input  logic signed [V_W-1:0]    v,
   input  logic signed [V_W-1:0]    u,
   input  logic signed [P_W-1:0]    a,
   input  logic signed [P_W-1:0]    b,
   input  logic signed [P_W-1:0]    c,
   input  logic signed [P_W-1:0]    d,
   input  logic signed [STIM_W-1:0] stim,
   output logic signed [V_W-1:0]    v_out,
   output logic signed [V_W-1:0]    u_out,
   output logic                     spike
);

   // Wide enough that v*v*K_SQ and a*(b*v - u) never wrap.
   localparam int W = 2 * V_W + P_W + 2;

   logic signed [W-1:0] sv, su, sa, sb, ss;
   logic signed [W-1:0] vsq, dv, v_sum, bv, du, u_sum, ud_sum;
   logic signed [V_W-1:0] v_new, u_new;

   always_comb begin
      sv = W'(v);
      su = W'(u);
      sa = W'(a);
      sb = W'(b);
      ss = W'(stim);
      // Both equations use the old v.
      vsq   = (sv * sv * W'(K_SQ)) >>> 8;
      dv    = vsq + sv * W'(5) + W'(140) - su + ss;
      v_sum = sv + dv;
      v_new = V_W'(sat(64'(v_sum), V_W));
      bv    = (sb * sv) >>> 8;
      du    = (sa * (bv - su)) >>> 8;
      u_sum = su + du;
      u_new = V_W'(sat(64'(u_sum), V_W));
      spike = (v_new >= V_W'(VPEAK));
      ud_sum = W'(u_new) + W'(d);
      v_out = spike ? V_W'(c) : v_new;
      u_out = spike ? V_W'(sat(64'(ud_sum), V_W)) : u_new;
   end

endmodule

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of N_NEURONS Izhikevich neurons on one datapath.
//   step          : run FETCH/CALC/WB for every neuron, then DONE
//   stim_in       : stimulus for neuron stim_idx, used in CALC
//   load_mode, serial_valid, serial_data : serial parameter frames,
//                   {idx, a, b, c, d} MSB first
//   mem_valid/mem_idx/mem_out/spike_valid : per-neuron result strobes (WB)
//   busy, step_done, params_ready, debug_state : status
//   enable low freezes every register and masks the strobes.
module izh_neuron_array
   import izh_pkg::*;
#(
   parameter int N_NEURONS = 4,
   parameter int IDX_W     = $clog2(N_NEURONS),
   parameter int V_W       = 16,
   parameter int P_W       = 8,
   parameter int STIM_W    = 8,
   parameter int OUT_W     = 8,
   parameter int K_SQ      = 10,
   parameter int VPEAK     = 30,
   parameter int V_RST     = DEF_V_RST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              step,
   input  logic [STIM_W-1:0] stim_in,
   output logic [IDX_W-1:0]  stim_idx,
   input  logic              load_mode,
   input  logic              serial_valid,
   input  logic              serial_data,
   output logic              mem_valid,
   output logic [IDX_W-1:0]  mem_idx,
   output logic [OUT_W-1:0]  mem_out,
   output logic              spike_valid,
   output logic              busy,
   output logic              step_done,
   output logic              params_ready,
   output logic [2:0]        debug_state
);

   localparam int FL    = frame_len(IDX_W, P_W);
   localparam int CNT_W = $clog2(FL);

   state_t state_q, state_d;
   logic [IDX_W-1:0] idx;

   logic [V_W-1:0] v_mem [N_NEURONS];
   logic [V_W-1:0] u_mem [N_NEURONS];
   logic [P_W-1:0] a_mem [N_NEURONS];
   logic [P_W-1:0] b_mem [N_NEURONS];
   logic [P_W-1:0] c_mem [N_NEURONS];
   logic [P_W-1:0] d_mem [N_NEURONS];
   logic [N_NEURONS-1:0] loaded;

   logic [V_W-1:0] r_v, r_u, wb_v, wb_u;
   logic [P_W-1:0] r_a, r_b, r_c, r_d;
   logic           wb_spk;
   logic [OUT_W-1:0] mem_out_q;

   logic [FL-1:0]    sh_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             wr_pend;

   logic signed [V_W-1:0] dp_v, dp_u;
   logic                  dp_spk;

   wire last_idx = (idx == IDX_W'(N_NEURONS - 1));

   izh_update_dp #(
      .V_W(V_W), .P_W(P_W), .STIM_W(STIM_W), .K_SQ(K_SQ), .VPEAK(VPEAK)
   ) u_dp (
      .v(r_v), .u(r_u), .a(r_a), .b(r_b), .c(r_c), .d(r_d),
      .stim(stim_in), .v_out(dp_v), .u_out(dp_u), .spike(dp_spk)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (load_mode) state_d = S_LOAD;
                  else if (step) state_d = S_FETCH;
         S_LOAD:  if (!load_mode) state_d = S_IDLE;
         S_FETCH: state_d = S_CALC;
         S_CALC:  state_d = S_WB;
         S_WB:    state_d = last_idx ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx       <= '0;
         loaded    <= '0;
         r_v <= '0; r_u <= '0; r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
         wb_v <= '0; wb_u <= '0; wb_spk <= 1'b0;
         mem_out_q <= '0;
         sh_q      <= '0;
         bit_cnt   <= '0;
         wr_pend   <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v_mem[i] <= V_W'(V_RST);
            u_mem[i] <= '0;
            a_mem[i] <= P_W'(DEF_A);
            b_mem[i] <= P_W'(DEF_B);
            c_mem[i] <= P_W'(DEF_C);
            d_mem[i] <= P_W'(DEF_D);
         end
      end else if (enable) begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (!load_mode && step) idx <= '0;
            S_FETCH: begin
               r_v <= v_mem[idx]; r_u <= u_mem[idx];
               r_a <= a_mem[idx]; r_b <= b_mem[idx];
               r_c <= c_mem[idx]; r_d <= d_mem[idx];
            end
            S_CALC: begin
               wb_v      <= dp_v;
               wb_u      <= dp_u;
               wb_spk    <= dp_spk;
               mem_out_q <= dp_v[V_W-1 -: OUT_W];
            end
            S_WB: begin
               v_mem[idx] <= wb_v;
               u_mem[idx] <= wb_u;
               if (!last_idx) idx <= idx + 1'b1;
            end
            default: ;
         endcase

         // A completed frame is committed the cycle after its last bit,
         // even if load_mode has dropped in the meantime.
         if (wr_pend) begin
            a_mem[sh_q[FL-1 -: IDX_W]] <= sh_q[4*P_W-1 -: P_W];
            b_mem[sh_q[FL-1 -: IDX_W]] <= sh_q[3*P_W-1 -: P_W];
            c_mem[sh_q[FL-1 -: IDX_W]] <= sh_q[2*P_W-1 -: P_W];
            d_mem[sh_q[FL-1 -: IDX_W]] <= sh_q[P_W-1:0];
            loaded[sh_q[FL-1 -: IDX_W]] <= 1'b1;
            wr_pend <= 1'b0;
         end
         if (state_q == S_LOAD) begin
            if (!load_mode) begin
               bit_cnt <= '0;
            end else if (serial_valid) begin
               sh_q <= {sh_q[FL-2:0], serial_data};
               if (bit_cnt == CNT_W'(FL - 1)) begin
                  bit_cnt <= '0;
                  wr_pend <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign stim_idx     = idx;
   assign mem_idx      = idx;
   assign mem_out      = mem_out_q;
   assign mem_valid    = enable && (state_q == S_WB);
   assign spike_valid  = enable && (state_q == S_WB) && wb_spk;
   assign step_done    = enable && (state_q == S_DONE);
   assign busy         = (state_q == S_FETCH) || (state_q == S_CALC) ||
                         (state_q == S_WB) || (state_q == S_DONE);
   assign params_ready = &loaded;
   assign debug_state  = state_q;

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array (N=4, default widths).
module tb_izh_neuron_array;

   logic       clk = 1'b0;
   logic       reset, enable, step, load_mode, serial_valid, serial_data;
   logic [7:0] stim_in;
   logic [1:0] stim_idx, mem_idx;
   logic [7:0] mem_out;
   logic       mem_valid, spike_valid, busy, step_done, params_ready;
   logic [2:0] debug_state;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   izh_neuron_array dut (
      .clk(clk), .reset(reset), .enable(enable), .step(step),
      .stim_in(stim_in), .stim_idx(stim_idx), .load_mode(load_mode),
      .serial_valid(serial_valid), .serial_data(serial_data),
      .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_out(mem_out),
      .spike_valid(spike_valid), .busy(busy), .step_done(step_done),
      .params_ready(params_ready), .debug_state(debug_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_neurons(input string tag, input int ev, input int eu);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_v%0d", tag, i), $signed(dut.v_mem[i]), ev);
         chk($sformatf("%s_u%0d", tag, i), $signed(dut.u_mem[i]), eu);
      end
   endtask

   // One full step; frz holds enable low for cycles 2..6 (CALC of neuron 0).
   task automatic run_step(input string tag, input logic [7:0] stim, input bit frz,
                           input bit exp_spk, input logic [7:0] exp_out);
      int sh;
      bit is_wb;
      sh = frz ? 5 : 0;
      stim_in = stim;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int c = 1; c <= 14 + sh; c++) begin
         if (frz) enable = !(c >= 2 && c < 7);
         #1;
         is_wb = (c >= 3 + sh) && ((c - 3 - sh) % 3 == 0) && ((c - 3 - sh) / 3 < 4);
         chk($sformatf("%s_memv_c%0d", tag, c), mem_valid, is_wb);
         chk($sformatf("%s_spk_c%0d", tag, c), spike_valid, is_wb && exp_spk);
         chk($sformatf("%s_done_c%0d", tag, c), step_done, c == 13 + sh);
         if (is_wb) begin
            chk($sformatf("%s_idx_c%0d", tag, c), mem_idx, (c - 3 - sh) / 3);
            chk($sformatf("%s_out_c%0d", tag, c), mem_out, exp_out);
         end
         if (frz && c >= 2 && c <= 7)
            chk($sformatf("%s_frz_c%0d", tag, c), debug_state, 3);
         tick();
      end
      enable = 1'b1;
   endtask

   task automatic send_frame(input logic [33:0] fr, input int nbits);
      for (int b = 33; b > 33 - nbits; b--) begin
         serial_valid = 1'b1;
         serial_data  = fr[b];
         tick();
      end
      serial_valid = 1'b0;
      serial_data  = 1'b0;
   endtask

   initial begin
      logic [33:0] fr;
      int ndone;
      reset = 1'b0; enable = 1'b1; step = 1'b0; stim_in = '0;
      load_mode = 1'b0; serial_valid = 1'b0; serial_data = 1'b0;

      // reset state
      do_reset();
      chk("rst_state", debug_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_memv", mem_valid, 0);
      chk("rst_out", mem_out, 0);
      chk("rst_ready", params_ready, 0);
      chk_neurons("rst", -65, 0);

      // stim 0: v -65 -> -85, u 0 -> -1; mem_out = top byte of 0xFFAB
      run_step("s0", 8'd0, 1'b0, 1'b0, 8'hFF);
      chk_neurons("s0", -85, -1);

      // stim 100: v -> 15, then 339 spikes: v=c=-65, u=-1+8=7
      do_reset();
      run_step("s100a", 8'd100, 1'b0, 1'b0, 8'h00);
      chk_neurons("s100a", 15, -1);
      run_step("s100b", 8'd100, 1'b0, 1'b1, 8'hFF);
      chk_neurons("s100b", -65, 7);

      // serial load of all four neurons
      do_reset();
      load_mode = 1'b1;
      tick();
      chk("ld_state", debug_state, 1);
      for (int i = 0; i < 4; i++) begin
         fr = {2'(i), 8'd2, 8'd51, 8'hCE, 8'd2};
         chk($sformatf("ld_ready_pre%0d", i), params_ready, 0);
         send_frame(fr, 34);
      end
      chk("ld_ready_lastbit", params_ready, 0);
      tick();
      chk("ld_ready", params_ready, 1);
      chk("ld_a3", $signed(dut.a_mem[3]), 2);
      chk("ld_c3", $signed(dut.c_mem[3]), -50);
      chk("ld_d0", $signed(dut.d_mem[0]), 2);
      load_mode = 1'b0;
      tick();
      chk("ld_exit", debug_state, 0);

      // partial frame aborted at bit 10
      do_reset();
      load_mode = 1'b1;
      tick();
      send_frame({2'd1, 8'd7, 8'd7, 8'd7, 8'd7}, 10);
      load_mode = 1'b0;
      tick();
      tick();
      chk("pf_state", debug_state, 0);
      chk("pf_cnt", dut.bit_cnt, 0);
      chk("pf_a1", $signed(dut.a_mem[1]), 5);
      chk("pf_ready", params_ready, 0);

      // step while busy is ignored: one step_done
      do_reset();
      ndone = 0;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int c = 1; c < 30; c++) begin
         step = (c == 5);
         #1;
         if (step_done) ndone++;
         tick();
      end
      step = 1'b0;
      chk("busy_ndone", ndone, 1);
      chk("busy_idle", debug_state, 0);

      // step with load_mode enters LOAD, not FETCH
      ndone = 0;
      load_mode = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("lstep_state", debug_state, 1);
      for (int c = 0; c < 15; c++) begin
         if (step_done) ndone++;
         tick();
      end
      chk("lstep_busy", busy, 0);
      load_mode = 1'b0;
      tick();
      chk("lstep_ndone", ndone, 0);
      chk("lstep_idle", debug_state, 0);

      // enable low for 5 cycles in CALC shifts completion by 5
      do_reset();
      run_step("frz", 8'd0, 1'b1, 1'b0, 8'hFF);
      chk_neurons("frz", -85, -1);

      // reset during WB of neuron 2
      do_reset();
      load_mode = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) send_frame({2'(i), 8'd5, 8'd51, 8'hBF, 8'd8}, 34);
      load_mode = 1'b0;
      tick();
      chk("mr_ready_pre", params_ready, 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int c = 1; c < 9; c++) tick();
      chk("mr_wb", debug_state, 4);
      chk("mr_wbidx", mem_idx, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_state", debug_state, 0);
      chk("mr_ready", params_ready, 0);
      chk_neurons("mr", -65, 0);
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (step_done) ndone++;
         tick();
      end
      chk("mr_ndone", ndone, 0);
      chk("mr_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
